// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: operation encoding,
// a segment add primitive and the parameter legality check.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_t;

    // Widest carry-chain segment the helper below can resolve.
    localparam int MAX_SEG = 64;

    function automatic logic [MAX_SEG:0] seg_add(
        input logic [MAX_SEG-1:0] a,
        input logic [MAX_SEG-1:0] b,
        input logic               cin
    );
        seg_add = {1'b0, a} + {1'b0, b} + {{MAX_SEG{1'b0}}, cin};
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        params_ok = (stages >= 32'sd1) && (stages <= width) &&
                    ((width % stages) == 32'sd0) && ((width / stages) <= MAX_SEG);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit carry-chain slice: sum and carry-out of a + b + cin.
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic [MAX_SEG:0] full_s;

    // Zero-extended inputs put the segment carry at bit SEG of the result.
    always_comb begin
        full_s = seg_add(MAX_SEG'(a), MAX_SEG'(b), cin);
    end

    assign sum  = full_s[SEG-1:0];
    assign cout = full_s[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES registered carry-chain segments,
// with valid/ready backpressure, synchronous flush and carry/overflow/zero flags.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_param_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    add_op_t          op_s;
    logic [STAGES-1:0] valid_r;
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic [STAGES-1:0] carry_r;
    logic              ovf_r;
    logic              zero_r;

    logic [STAGES-1:0] acc_s;
    logic [STAGES-1:0] src_valid_s;
    logic [STAGES-1:0] src_cin_s;
    logic [STAGES-1:0] seg_cout_s;
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_b_s   [STAGES];
    logic [WIDTH-1:0]  src_sum_s [STAGES];
    logic [WIDTH-1:0]  nxt_sum_s [STAGES];
    logic [SEG-1:0]    seg_sum_s [STAGES];
    logic              in_fire_s;
    logic              nxt_ovf_s;
    logic              nxt_zero_s;

    assign op_s = in_sub ? OP_SUB : OP_ADD;

    // Stage k can load when out_ready is high or any stage from k to the output is empty.
    always_comb begin
        logic [STAGES-1:0] low_v;
        for (int k = 0; k < STAGES; k++) begin
            low_v = '0;
            for (int j = 0; j < k; j++) begin
                low_v[j] = 1'b1;
            end
            acc_s[k] = out_ready | ~(&(valid_r | low_v));
        end
    end

    assign in_ready  = acc_s[0] & ~flush;
    assign in_fire_s = in_valid & in_ready;

    // Each stage consumes the operands of the stage behind it; stage 0 sees the inputs.
    always_comb begin
        src_valid_s[0] = in_fire_s;
        src_a_s[0]     = in_a;
        src_sum_s[0]   = '0;
        if (op_s == OP_SUB) begin
            src_b_s[0]   = ~in_b;
            src_cin_s[0] = 1'b1;
        end else begin
            src_b_s[0]   = in_b;
            src_cin_s[0] = in_cin;
        end
        for (int k = 1; k < STAGES; k++) begin
            src_valid_s[k] = valid_r[k-1];
            src_a_s[k]     = a_r[k-1];
            src_b_s[k]     = b_r[k-1];
            src_sum_s[k]   = sum_r[k-1];
            src_cin_s[k]   = carry_r[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        adder_segment #(
            .SEG(SEG)
        ) u_seg (
            .a    (src_a_s[g][g*SEG +: SEG]),
            .b    (src_b_s[g][g*SEG +: SEG]),
            .cin  (src_cin_s[g]),
            .sum  (seg_sum_s[g]),
            .cout (seg_cout_s[g])
        );
    end

    // Merge each resolved segment into the partial sum; flags come from the final stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum_s[k]                = src_sum_s[k];
            nxt_sum_s[k][k*SEG +: SEG]  = seg_sum_s[k];
        end
        nxt_ovf_s  = (src_a_s[LAST][WIDTH-1] == src_b_s[LAST][WIDTH-1]) &&
                     (nxt_sum_s[LAST][WIDTH-1] != src_a_s[LAST][WIDTH-1]);
        nxt_zero_s = ~|nxt_sum_s[LAST];
    end

    // Stage registers: valid bits follow the advance rule, data loads only with a live beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            carry_r <= '0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    valid_r[k] <= 1'b0;
                end else if (acc_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                end else begin
                    valid_r[k] <= valid_r[k];
                end
                if (!flush && acc_s[k] && src_valid_s[k]) begin
                    a_r[k]     <= src_a_s[k];
                    b_r[k]     <= src_b_s[k];
                    sum_r[k]   <= nxt_sum_s[k];
                    carry_r[k] <= seg_cout_s[k];
                end
            end
            if (!flush && acc_s[LAST] && src_valid_s[LAST]) begin
                ovf_r  <= nxt_ovf_s;
                zero_r <= nxt_zero_s;
            end
        end
    end

    assign out_valid = valid_r[LAST];
    assign out_sum   = sum_r[LAST];
    assign out_cout  = carry_r[LAST];
    assign out_ovf   = ovf_r;
    assign out_zero  = zero_r;

endmodule
